detranspose: RTL

Inverse of the DWT column-output transpose, used on the IDWT path. Accepts row-ordered sample pairs, two beats per group: beat A carries (L0, L1) and beat B carries (H0, H1). It re-emits them as column-ordered low/high pairs, (L0, H0) then (L1, H1), to the inverse column filter. Throughput is one output pair per cycle; the stream advances only while `dwt_work` is high.

---
 rtl/detranspose.sv | 89 ++++++++
 1 files changed

// File: rtl/detranspose.sv
// detranspose: inverse of the DWT column-output transpose on the IDWT path.
// Takes row-ordered beats A=(L0,L1), B=(H0,H1) and emits column-ordered
// pairs (L0,H0) then (L1,H1), one pair per cycle while dwt_work is high.
// Optional feature: define DETRANS_ERR_EN to build the sticky pair_err flag;
// without it pair_err is tied low and no error logic exists.
module detranspose #(
    parameter int DW = 16
) (
    input  logic          clk_tr,
    input  logic          rst_syn,
    input  logic          dwt_work,
    input  logic [DW-1:0] row_in1,
    input  logic [DW-1:0] row_in2,
    input  logic          row_vld,
    output logic [DW-1:0] col_ldata,
    output logic [DW-1:0] col_hdata,
    output logic          col_vld,
    output logic          pair_err
);

    logic          ph;        // 0: expecting beat A, 1: expecting beat B
    logic [DW-1:0] la0, la1;  // held beat A samples
    logic [DW-1:0] pl, ph1;   // second pair waiting to be drained
    logic          pend;

    logic beat_a, beat_b;
    assign beat_a = row_vld & ~ph;
    assign beat_b = row_vld &  ph;

    // Phase tracking; a missing valid inside a group drops the held A beat
    always_ff @(posedge clk_tr) begin
        if (rst_syn)
            ph <= 1'b0;
        else if (dwt_work)
            ph <= row_vld ? ~ph : 1'b0;
    end

    // Beat A capture
    always_ff @(posedge clk_tr) begin
        if (rst_syn) begin
            la0 <= '0;
            la1 <= '0;
        end else if (dwt_work && beat_a) begin
            la0 <= row_in1;
            la1 <= row_in2;
        end
    end

    // Output pair and pending pair: beat B wins over a drain
    always_ff @(posedge clk_tr) begin
        if (rst_syn) begin
            col_ldata <= '0;
            col_hdata <= '0;
            col_vld   <= 1'b0;
            pl        <= '0;
            ph1       <= '0;
            pend      <= 1'b0;
        end else if (dwt_work) begin
            if (beat_b) begin
                col_ldata <= la0;
                col_hdata <= row_in1;
                col_vld   <= 1'b1;
                pl        <= la1;
                ph1       <= row_in2;
                pend      <= 1'b1;
            end else if (pend) begin
                col_ldata <= pl;
                col_hdata <= ph1;
                col_vld   <= 1'b1;
                pend      <= 1'b0;
            end else begin
                col_vld   <= 1'b0;
            end
        end
    end

`ifdef DETRANS_ERR_EN
    // Sticky error: broken group, or beat B arriving over an undrained pair
    always_ff @(posedge clk_tr) begin
        if (rst_syn)
            pair_err <= 1'b0;
        else if (dwt_work && ((ph && !row_vld) || (beat_b && pend)))
            pair_err <= 1'b1;
    end
`else
    assign pair_err = 1'b0;
`endif

endmodule
